// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter.
//   state_e    : transmitter FSM states
//   LINE_IDLE  : level the serial line rests at between frames
//   frame_bits : number of bit periods in one frame (start + data + parity + stop)
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int frame_bits(input int data_w, input int parity_en);
    return 2 + data_w + ((parity_en != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer.
//   Clk, Reset : clock, synchronous active-high reset
//   clear      : forces the count back to 0 (wins over en)
//   en         : count enable
//   tick       : high on the cycle the count sits at CLKS_PER_BIT-1; the
//                count wraps to 0 on the following edge
module baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  // A one-cycle bit period still needs a 1-bit counter that simply stays at 0.
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] TERM = BW'(CLKS_PER_BIT - 1);

  logic [BW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: on a rising edge of TxData while idle, latches DataIn
// and sends start bit, data LSB first, optional even parity, stop bit.
//   Clk, Reset : clock, synchronous active-high reset
//   TxData     : transmit request level; only its rising edge starts a frame
//   DataIn     : parallel word, sampled on the start edge only
//   SerOut     : serial line, idles high
//   TxBusy     : high while a frame is in progress
//   TxDone     : one-cycle pulse as the stop bit completes
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              TxData,
  input  logic [DATA_W-1:0] DataIn,
  output logic              SerOut,
  output logic              TxBusy,
  output logic              TxDone
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              parity_q, parity_d;
  logic              ser_q, ser_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tx_data_q, tx_data_d;

  logic start;
  logic tick;

  // The controller holds TxData until it sees TxDone, so only a rising edge
  // seen while idle may start a frame.
  assign start = TxData && !tx_data_q && (state_q == IDLE);

  // Timer is held at 0 while idle and restarted on the start edge so the
  // start bit gets a full period.
  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .Clk  (Clk),
    .Reset(Reset),
    .clear(start || !busy_q),
    .en   (busy_q),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    ser_d     = ser_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tx_data_d = TxData;

    case (state_q)
      IDLE: begin
        ser_d = LINE_IDLE;
        if (start) begin
          shreg_d  = DataIn;
          parity_d = ^DataIn;
          state_d  = START;
          ser_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          ser_d     = shreg_q[0];
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              ser_d   = parity_q;
            end else begin
              state_d = STOP;
              ser_d   = LINE_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            ser_d     = shreg_d[0];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          ser_d   = LINE_IDLE;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ser_d   = LINE_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      ser_q     <= LINE_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_data_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      ser_q     <= ser_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign SerOut = ser_q;
  assign TxBusy = busy_q;
  assign TxDone = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx. Three instances:
//   0: parity on,  4 clocks/bit    1: parity off, 4 clocks/bit
//   2: parity on,  1 clock/bit
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx   [3];
  logic [7:0] din  [3];
  logic       ser  [3];
  logic       busy [3];
  logic       done [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (
    .Clk(clk), .Reset(rst), .TxData(tx[0]), .DataIn(din[0]),
    .SerOut(ser[0]), .TxBusy(busy[0]), .TxDone(done[0]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut1 (
    .Clk(clk), .Reset(rst), .TxData(tx[1]), .DataIn(din[1]),
    .SerOut(ser[1]), .TxBusy(busy[1]), .TxDone(done[1]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut2 (
    .Clk(clk), .Reset(rst), .TxData(tx[2]), .DataIn(din[2]),
    .SerOut(ser[2]), .TxBusy(busy[2]), .TxDone(done[2]));

  // ---------------- reference model ----------------
  function automatic int cpb_of(input int idx);
    return (idx == 2) ? 1 : 4;
  endfunction

  function automatic int par_of(input int idx);
    return (idx == 1) ? 0 : 1;
  endfunction

  function automatic int frame_len(input int idx);
    return 10 + par_of(idx);
  endfunction

  // Line level during bit period 'pos' of a frame carrying word w.
  function automatic logic exp_bit(input int idx, input logic [7:0] w, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return w[pos-1];
    if (pos == 9 && par_of(idx) == 1) return ^w;
    return 1'b1;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic ok, input int act, input int req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Outputs must sit idle (line high, not busy, no done) for n cycles.
  task automatic check_idle(input int idx, input int n, input string name);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (ser[idx] !== 1'b1 || busy[idx] !== 1'b0 || done[idx] !== 1'b0) bad++;
    end
    check(name, bad == 0, bad, 0);
  endtask

  // Raise TxData with 'word' now (caller guarantees TxData was low for at
  // least one edge), then follow the whole frame cycle by cycle. Optional
  // mid-frame disturbances: drop/raise TxData, change DataIn (-1 = none).
  task automatic run_frame(input int idx, input logic [7:0] word,
                           input int drop_at, input int rise_at,
                           input int chg_at, input logic [7:0] chg_val,
                           input int exp_done, input int exp_par);
    int c, f, line_bad, busy_bad, par_bad, n_done, done_at, pos;
    c = cpb_of(idx);
    f = frame_len(idx);
    line_bad = 0; busy_bad = 0; par_bad = 0; n_done = 0; done_at = -1;
    tx[idx]  = 1'b1;
    din[idx] = word;
    for (int k = 1; k <= f * c + 2; k++) begin
      @(negedge clk);
      if (done[idx] === 1'b1) begin
        n_done++;
        done_at = k;
      end
      if (k <= f * c) begin
        pos = (k - 1) / c;
        if (ser[idx] !== exp_bit(idx, word, pos)) line_bad++;
        if (busy[idx] !== 1'b1) busy_bad++;
        if (par_of(idx) == 1 && pos == 9 && ser[idx] !== exp_par[0]) par_bad++;
      end else begin
        if (ser[idx] !== 1'b1) line_bad++;
        if (busy[idx] !== 1'b0) busy_bad++;
      end
      if (k == drop_at) tx[idx] = 1'b0;
      if (k == rise_at) tx[idx] = 1'b1;
      if (k == chg_at)  din[idx] = chg_val;
    end
    $display("[TB] frame dut%0d word=%02h line_err=%0d busy_err=%0d done_at=%0d",
             idx, word, line_bad, busy_bad, done_at - 1);
    check("line", line_bad == 0, line_bad, 0);
    check("busy", busy_bad == 0, busy_bad, 0);
    check("done_at", n_done == 1 && done_at == exp_done + 1, done_at - 1, exp_done);
    if (par_of(idx) == 1) check("parity", par_bad == 0, par_bad, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         idx;
    logic [7:0] word;
    int         drop_at;
    int         rise_at;
    int         chg_at;
    logic [7:0] chg_val;
    int         exp_done;   // cycles from start edge to TxDone
    int         exp_par;    // parity bit expected on the line
  } vec_t;

  vec_t vecs [6];

  initial begin
    int idx, f, c, d, r;
    logic [7:0] w;

    vecs[0] = '{0, 8'hA5, -1, -1, -1, 8'h00, 44, 0};
    vecs[1] = '{0, 8'h07, -1, -1, -1, 8'h00, 44, 1};
    vecs[2] = '{1, 8'h07, -1, -1, -1, 8'h00, 40, 0};
    vecs[3] = '{2, 8'hA5, -1, -1, -1, 8'h00, 11, 0};
    vecs[4] = '{0, 8'hA5,  8, 10, 12, 8'hFF, 44, 0};
    vecs[5] = '{2, 8'h3C,  2,  4,  3, 8'hC3, 11, 0};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx[i]  = 1'b0;
      din[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) check_idle(i, 20, "reset_idle");

    // Table: each frame, then TxData stays high -> must not retrigger.
    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].idx, vecs[v].word, vecs[v].drop_at, vecs[v].rise_at,
                vecs[v].chg_at, vecs[v].chg_val, vecs[v].exp_done, vecs[v].exp_par);
      check_idle(vecs[v].idx, 8, "no_retrigger");
      tx[vecs[v].idx] = 1'b0;
      @(negedge clk);
    end

    // Reset at cycle 20 of a frame: abort, no TxDone, then a clean frame.
    tx[0] = 1'b1;
    din[0] = 8'hA5;
    for (int k = 1; k <= 20; k++) @(negedge clk);
    rst = 1'b1;
    tx[0] = 1'b0;
    @(negedge clk);
    $display("[TB] abort ser=%0b busy=%0b done=%0b", ser[0], busy[0], done[0]);
    check("abort", ser[0] === 1'b1 && busy[0] === 1'b0 && done[0] === 1'b0,
          {busy[0], done[0], ser[0]}, 1);
    rst = 1'b0;
    check_idle(0, 50, "abort_quiet");
    run_frame(0, 8'h5A, -1, -1, -1, 8'h00, 44, 0);
    tx[0] = 1'b0;
    @(negedge clk);

    // Back-to-back: drop TxData the cycle after TxDone, then raise again.
    run_frame(0, 8'h81, -1, -1, -1, 8'h00, 44, 0);
    tx[0] = 1'b0;
    @(negedge clk);
    run_frame(0, 8'h6E, -1, -1, -1, 8'h00, 44, 1);
    tx[0] = 1'b0;
    @(negedge clk);

    // Randomised frames with random mid-frame disturbances.
    for (int n = 0; n < 24; n++) begin
      idx = $urandom_range(0, 2);
      w   = 8'($urandom);
      c   = cpb_of(idx);
      f   = frame_len(idx);
      d   = $urandom_range(1, f * c - 2);
      r   = $urandom_range(d + 1, f * c);
      run_frame(idx, w, d, r, $urandom_range(1, f * c), 8'($urandom), f * c, int'(^w));
      tx[idx] = 1'b0;
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
